// File: rtl/usb_tx_encoder_if.sv
// Transmit-side bus of the USB low-level encoder: byte handshake plus line drive.
interface usb_tx_encoder_if #(
    parameter int BYTE_W = 8
);
    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              dplus_out;
    logic              dminus_out;
    logic              tx_active;

    modport master (
        output tx_start, tx_data, tx_valid,
        input  tx_ready, dplus_out, dminus_out, tx_active
    );

    modport slave (
        input  tx_start, tx_data, tx_valid,
        output tx_ready, dplus_out, dminus_out, tx_active
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: SYNC, NRZI data with bit stuffing, EOP, on an 8/8/9-clock bit cadence.
module usb_tx_encoder #(
    parameter int CNT_BITS = 5,
    parameter int BYTE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_encoder_if.slave    bus
);
    localparam int BC_W = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;
    localparam logic [BC_W-1:0]     LAST_BIT  = BC_W'(BYTE_W - 1);
    localparam logic [BYTE_W-1:0]   SYNC_PAT  = {1'b1, {(BYTE_W-1){1'b0}}};
    localparam logic [CNT_BITS-1:0] LEN8_LAST = CNT_BITS'(7);
    localparam logic [CNT_BITS-1:0] LEN9_LAST = CNT_BITS'(8);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [1:0]          phase;
    logic [2:0]          ones;
    logic [BC_W-1:0]     bit_cnt;
    logic [BYTE_W-1:0]   shreg;

    logic [CNT_BITS-1:0] last_cnt;
    logic                period_last, period_prelast;
    logic                in_bit, stuff_due, byte_done;
    logic                start, load, next_in_byte, emit;
    logic [BYTE_W-1:0]   src;

    // Bit-period boundaries and the source of the next NRZI bit
    always_comb begin
        last_cnt       = (phase == 2'd2) ? LEN9_LAST : LEN8_LAST;
        period_last    = (cnt == last_cnt);
        period_prelast = (cnt == last_cnt - CNT_BITS'(1));
        in_bit         = (state == SYNC) || (state == DATA);
        stuff_due      = (ones == 3'd6);
        // Byte boundary is the 8th bit itself, or the stuff bit that trails it
        byte_done      = (bit_cnt == LAST_BIT) && ((state == STUFF) || (in_bit && !stuff_due));
        start          = (state == IDLE) && bus.tx_start;
        load           = period_last && byte_done && bus.tx_valid;
        next_in_byte   = period_last && (bit_cnt != LAST_BIT) &&
                         ((state == STUFF) || (in_bit && !stuff_due));
        emit           = start || load || next_in_byte;
        src            = start ? SYNC_PAT : (load ? bus.tx_data : shreg);
    end

    // Packet FSM, bit timing, NRZI line drive and byte handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.dplus_out  <= 1'b1;
            bus.dminus_out <= 1'b0;
            bus.tx_ready   <= 1'b0;
            bus.tx_active  <= 1'b0;
            cnt            <= '0;
            phase          <= '0;
            ones           <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
        end else begin
            // Registered pulse lands on the last clock of the byte-closing period
            bus.tx_ready <= period_prelast && byte_done;

            if (state == IDLE) begin
                cnt   <= '0;
                phase <= '0;
            end else if (period_last) begin
                cnt   <= '0;
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end else begin
                cnt <= cnt + CNT_BITS'(1);
            end

            if (emit) begin
                shreg <= src >> 1;
                if (src[0]) begin
                    ones <= ones + 3'd1;
                end else begin
                    ones           <= '0;
                    bus.dplus_out  <= bus.dminus_out;
                    bus.dminus_out <= bus.dplus_out;
                end
                bit_cnt <= (start || load) ? '0 : bit_cnt + BC_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= SYNC;
                        bus.tx_active <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (period_last) begin
                        if (stuff_due) begin
                            state          <= STUFF;
                            ones           <= '0;
                            bus.dplus_out  <= bus.dminus_out;
                            bus.dminus_out <= bus.dplus_out;
                        end else if (bit_cnt == LAST_BIT && !bus.tx_valid) begin
                            state          <= EOP_SE0;
                            bit_cnt        <= '0;
                            bus.dplus_out  <= 1'b0;
                            bus.dminus_out <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                STUFF: begin
                    if (period_last) begin
                        if (bit_cnt == LAST_BIT && !bus.tx_valid) begin
                            state          <= EOP_SE0;
                            bit_cnt        <= '0;
                            bus.dplus_out  <= 1'b0;
                            bus.dminus_out <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                EOP_SE0: begin
                    if (period_last) begin
                        if (bit_cnt == BC_W'(1)) begin
                            state          <= EOP_J;
                            bus.dplus_out  <= 1'b1;
                            bus.dminus_out <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                EOP_J: begin
                    if (period_last) begin
                        state         <= IDLE;
                        bus.tx_active <= 1'b0;
                        ones          <= '0;
                        bit_cnt       <= '0;
                        shreg         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: expected line symbols per bit period are queued
// by the driver and checked by an independent monitor on the falling clock edge.
module tb_usb_tx_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    usb_tx_encoder_if #(.BYTE_W(8)) bus ();

    usb_tx_encoder #(.CNT_BITS(5), .BYTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] sym;   // {dplus, dminus}
        logic       rdy;   // tx_ready expected on the last clock of this period
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // 'J','K','0' = one bit period each; '|' marks tx_ready on the preceding period
    task automatic push_expect(input string s);
        byte  c;
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            if (c != "|") begin
                e.sym = (c == "J") ? 2'b10 : (c == "K") ? 2'b01 : 2'b00;
                e.rdy = (i + 1 < s.len()) && (s.getc(i + 1) == "|");
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: walks the 8/8/9 cadence while tx_active is high and scores each period
    initial begin : monitor
        bit   prev = 1'b0;
        int   idx = 0;
        int   ph = 0;
        int   act_cnt = 0;
        int   plen;
        int   want_len;
        exp_t cur;
        cur = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.tx_active) begin
                    if (!prev) begin
                        idx = 0;
                        ph = 0;
                        act_cnt = 0;
                    end
                    act_cnt++;
                    plen = (ph == 2) ? 9 : 8;
                    if (idx == 0) begin
                        check("expect_avail", 32'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) cur = exp_q.pop_front();
                        check("sym_first", {bus.dplus_out, bus.dminus_out}, cur.sym);
                        check("ready_first", bus.tx_ready, 0);
                    end
                    if (idx == plen - 1) begin
                        check("sym_last", {bus.dplus_out, bus.dminus_out}, cur.sym);
                        check("ready_last", bus.tx_ready, cur.rdy);
                        idx = 0;
                        ph = (ph + 1) % 3;
                    end else begin
                        idx++;
                    end
                end else if (prev) begin
                    want_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
                    check("active_len", act_cnt, want_len);
                    check("periods_left", exp_q.size(), 0);
                    check("line_after_eop", {bus.dplus_out, bus.dminus_out}, 2'b10);
                    exp_q.delete();
                end
            end
            prev = bus.tx_active;
        end
    end

    task automatic run_packet(input string name, input logic [15:0] bytes, input int nbytes,
                              input string exp_s, input int exp_len, input bit poke_start);
        int k = 0;
        bit done = 1'b0;
        bit idle_ok;
        push_expect(exp_s);
        len_q.push_back(exp_len);
        @(posedge clk) #1 bus.tx_start = 1'b1;
        @(posedge clk) #1 bus.tx_start = 1'b0;
        check({name, "_sync_start"}, {bus.dplus_out, bus.dminus_out, bus.tx_active}, 3'b011);
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (!bus.tx_active) begin
                done = 1'b1;
            end else begin
                if (poke_start) bus.tx_start = (cyc == 100);
                if (bus.tx_ready) begin
                    if (k < nbytes) begin
                        bus.tx_data  = bytes[8*k +: 8];
                        bus.tx_valid = 1'b1;
                        k++;
                    end else begin
                        bus.tx_valid = 1'b0;
                    end
                    @(posedge clk) #1;
                    bus.tx_valid = 1'b0;
                    bus.tx_data  = 8'($urandom);
                end
            end
        end
        bus.tx_start = 1'b0;
        check({name, "_terminated"}, done, 1);
        idle_ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if ({bus.dplus_out, bus.dminus_out, bus.tx_active, bus.tx_ready} != 4'b1000)
                idle_ok = 1'b0;
        end
        check({name, "_idle_after"}, idle_ok, 1);
    endtask

    initial begin : driver
        bit idle_ok;
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.dplus_out, bus.dminus_out, bus.tx_active, bus.tx_ready}, 4'b1000);
        @(posedge clk) #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_release", {bus.dplus_out, bus.dminus_out, bus.tx_active}, 3'b100);
        mon_en = 1'b1;

        run_packet("byte00", 16'h0000, 1, "KJKJKJKK|JKJKJKJK|00J", 158, 1'b0);
        run_packet("byteFF", 16'h00FF, 1, "KJKJKJKK|KKKKKJJJJ|00J", 166, 1'b0);
        run_packet("byte3F_00", 16'h003F, 2, "KJKJKJKK|KKKKKJJKJ|KJKJKJKJ|00J", 233, 1'b0);
        run_packet("start_poke", 16'h0055, 1, "KJKJKJKK|KJJKKJJK|00J", 158, 1'b1);

        // Mid-packet reset: line must snap back to J with no EOP
        mon_en       = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge clk) #1 bus.tx_start = 1'b1;
        @(posedge clk) #1 bus.tx_start = 1'b0;
        repeat (90) @(posedge clk);
        #1 check("active_before_reset", bus.tx_active, 1);
        #2 rst = 1'b1;
        #1 check("reset_mid_packet", {bus.dplus_out, bus.dminus_out, bus.tx_active, bus.tx_ready}, 4'b1000);
        @(posedge clk) #1 rst = 1'b0;
        bus.tx_valid = 1'b0;
        idle_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if ({bus.dplus_out, bus.dminus_out, bus.tx_active} != 3'b100) idle_ok = 1'b0;
        end
        check("idle_after_abort", idle_ok, 1);
        exp_q.delete();
        len_q.delete();
        mon_en = 1'b1;

        run_packet("after_reset", 16'h0000, 1, "KJKJKJKK|JKJKJKJK|00J", 158, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
